// File: rtl/bram_lane_clr_if.sv
// Port bundle for bram_lane_clr: write port, read port, zero-fill control and read-data return.
interface bram_lane_clr_if #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 10
);
  logic                   clr;
  logic                   busy;
  logic [LANES-1:0]       wen;
  logic [DEPTH-1:0]       waddr;
  logic [LANES*DSIZE-1:0] din;
  logic                   ren;
  logic [DEPTH-1:0]       raddr;
  logic [LANES*DSIZE-1:0] dout;
  logic                   dvalid;

  modport master (
    output clr, wen, waddr, din, ren, raddr,
    input  busy, dout, dvalid
  );

  modport slave (
    input  clr, wen, waddr, din, ren, raddr,
    output busy, dout, dvalid
  );
endinterface

// File: rtl/bram_lane_clr.sv
// Multi-lane simple dual-port block RAM with per-lane write enables, 1..3 cycle read latency,
// selectable read-during-write behaviour and a hardware zero-fill engine.
module bram_lane_clr #(
  parameter int unsigned DSIZE   = 32,
  parameter int unsigned LANES   = 2,
  parameter int unsigned MSIZE   = 1024,
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned WR_MODE = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  bram_lane_clr_if.slave     bus
);
  localparam int unsigned W = LANES * DSIZE;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] cnt_q, cnt_d;
  logic             busy;

  logic             wr_ok, rd_ok, rd_acc, collide;
  logic [LANES-1:0] mem_we;
  logic [DEPTH-1:0] mem_waddr;
  logic [W-1:0]     mem_wdata;

  (* ram_style = "block" *) logic [W-1:0] mem_q [MSIZE];
  logic [W-1:0]     ram_q;

  logic             v1_q;
  logic             zero_q;
  logic [LANES-1:0] fmask_q;
  logic [W-1:0]     fdata_q;
  logic [W-1:0]     word;

  assign busy     = (state_q == StClear);
  assign bus.busy = busy;

  assign wr_ok   = (32'(bus.waddr) < MSIZE);
  assign rd_ok   = (32'(bus.raddr) < MSIZE);
  assign rd_acc  = bus.ren && !busy;
  assign collide = !busy && wr_ok && rd_ok && (bus.waddr == bus.raddr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEPTH'(MSIZE - 1)) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
        if (bus.clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // The fill engine takes over the single write port while busy.
  always_comb begin
    mem_we    = '0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.din;
    if (busy) begin
      mem_we    = '1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = bus.wen;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (mem_we[l]) begin
        mem_q[mem_waddr][l*DSIZE +: DSIZE] <= mem_wdata[l*DSIZE +: DSIZE];
      end
    end
    if (rd_acc && rd_ok) begin
      ram_q <= mem_q[bus.raddr];
    end
  end

  // zero_q resets high so the unreset array register never leaks onto dout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      zero_q  <= 1'b1;
      fmask_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= rd_acc;
      if (rd_acc) begin
        zero_q  <= !rd_ok;
        fmask_q <= ((WR_MODE == 1) && collide) ? bus.wen : '0;
        fdata_q <= bus.din;
      end
    end
  end

  always_comb begin
    word = ram_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (fmask_q[l]) begin
        word[l*DSIZE +: DSIZE] = fdata_q[l*DSIZE +: DSIZE];
      end
    end
    if (zero_q) begin
      word = '0;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign bus.dout   = word;
    assign bus.dvalid = v1_q;
  end else begin : g_latn
    logic [W-1:0]        pd_q [RD_LAT-1];
    logic [RD_LAT-2:0]   pv_q;

    // Data stages only load on a valid beat so dout holds between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < RD_LAT - 1; i++) begin
          pd_q[i] <= '0;
        end
        pv_q <= '0;
      end else begin
        pv_q[0] <= v1_q;
        if (v1_q) begin
          pd_q[0] <= word;
        end
        for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
          if (pv_q[i-1]) begin
            pd_q[i] <= pd_q[i-1];
          end
        end
      end
    end

    assign bus.dout   = pd_q[RD_LAT-2];
    assign bus.dvalid = pv_q[RD_LAT-2];
  end
endmodule

// File: tb/tb_bram_lane_clr.sv
// Directed bench driving four bram_lane_clr configurations from one shared stimulus stream.
module tb_bram_lane_clr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr, ren;
  logic [1:0]  wen;
  logic [3:0]  waddr, raddr;
  logic [63:0] din;

  logic        busy_w [4];
  logic        dv_w   [4];
  logic [63:0] dout_w [4];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] rd_q [4][$];
  int          rc_q [4][$];
  logic [63:0] exp_w [4][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: MSIZE16 lat1 read-first, 1: lat2 write-first, 2: lat3 read-first, 3: MSIZE12 lat1 write-first
  bram_lane_clr_if #(.DSIZE(32), .LANES(2), .DEPTH(4)) bif [4] ();

  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign bif[k].clr   = clr;
    assign bif[k].wen   = wen;
    assign bif[k].waddr = waddr;
    assign bif[k].din   = din;
    assign bif[k].ren   = ren;
    assign bif[k].raddr = raddr;
    assign busy_w[k]    = bif[k].busy;
    assign dv_w[k]      = bif[k].dvalid;
    assign dout_w[k]    = bif[k].dout;

    bram_lane_clr #(
      .DSIZE  (32),
      .LANES  (2),
      .MSIZE  ((k == 3) ? 12 : 16),
      .DEPTH  (4),
      .RD_LAT ((k == 1) ? 2 : (k == 2) ? 3 : 1),
      .WR_MODE((k == 1 || k == 3) ? 1 : 0)
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bif[k])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv_w[k]) begin
        rd_q[k].push_back(dout_w[k]);
        rc_q[k].push_back(cyc);
      end
    end
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 3 : 1;
  endfunction

  function automatic int ms_of(input int k);
    return (k == 3) ? 12 : 16;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0;
    ren = 1'b0;
    wen = 2'b00;
  endtask

  task automatic set_exp(input int i, input logic [63:0] v);
    for (int k = 0; k < 4; k++) exp_w[k][i] = v;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 4; k++) begin
      rd_q[k].delete();
      rc_q[k].delete();
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] we, input logic [63:0] d);
    waddr = a;
    wen   = we;
    din   = d;
    tick();
    wen = 2'b00;
  endtask

  task automatic rd_burst(input int base, input int n, output int first);
    first = 0;
    for (int i = 0; i < n; i++) begin
      ren   = 1'b1;
      raddr = 4'(base + i);
      tick();
      if (i == 0) first = cyc;
    end
    ren = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_reads(input string tag, input int first, input int n);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("%s d%0d count", tag, k), 64'(rd_q[k].size()), 64'(n));
      for (int i = 0; i < n && i < rd_q[k].size(); i++) begin
        check_val($sformatf("%s d%0d data[%0d]", tag, k, i), rd_q[k][i], exp_w[k][i]);
        check_val($sformatf("%s d%0d cycle[%0d]", tag, k, i), 64'(rc_q[k][i]),
                  64'(first + lat_of(k) - 1 + i));
      end
    end
    clear_logs();
  endtask

  // inject: a write and read to address 0 mid-fill, plus a second clr pulse.
  task automatic measure_busy(input string tag, input bit inject);
    int n [4];
    for (int k = 0; k < 4; k++) n[k] = 0;
    for (int c = 1; c <= 40; c++) begin
      idle();
      if (inject && c == 2) begin
        wen   = 2'b11;
        waddr = 4'd0;
        din   = 64'h0000_0044_0000_0044;
        ren   = 1'b1;
        raddr = 4'd0;
      end
      if (inject && c == 5) clr = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) if (!busy_w[k] && n[k] == 0) n[k] = c;
    end
    idle();
    for (int k = 0; k < 4; k++) check_val($sformatf("%s d%0d", tag, k), 64'(n[k]), 64'(ms_of(k)));
  endtask

  task automatic collide(input logic [1:0] we, input logic [63:0] d, input string tag,
                         input logic [63:0] exp_rf, input logic [63:0] exp_wf);
    int first;
    waddr = 4'd3;
    wen   = we;
    din   = d;
    ren   = 1'b1;
    raddr = 4'd3;
    tick();
    first = cyc;
    idle();
    repeat (4) tick();
    for (int k = 0; k < 4; k++) exp_w[k][0] = (k == 1 || k == 3) ? exp_wf : exp_rf;
    check_reads(tag, first, 1);
  endtask

  initial begin
    int first;
    idle();
    waddr = '0;
    raddr = '0;
    din   = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("reset busy d%0d", k), 64'(busy_w[k]), 64'd1);
      check_val($sformatf("reset dvalid d%0d", k), 64'(dv_w[k]), 64'd0);
      check_val($sformatf("reset dout d%0d", k), dout_w[k], 64'd0);
    end
    rst_n = 1'b1;
    measure_busy("fill busy", 1'b0);

    for (int i = 0; i < 16; i++) set_exp(i, 64'd0);
    rd_burst(0, 16, first);
    check_reads("fill zero", first, 16);

    wr(4'd5, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001});
    wr(4'd5, 2'b01, {32'hDEAD_BEEF, 32'h0000_00FF});
    set_exp(0, {32'hBBBB_0002, 32'h0000_00FF});
    rd_burst(5, 1, first);
    check_reads("lane write", first, 1);
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("hold dout d%0d", k), dout_w[k], {32'hBBBB_0002, 32'h0000_00FF});
      check_val($sformatf("hold dvalid d%0d", k), 64'(dv_w[k]), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      wr(4'(i), 2'b11, {32'd0, 32'(i + 100)});
      set_exp(i, {32'd0, 32'(i + 100)});
    end
    rd_burst(0, 8, first);
    check_reads("sweep", first, 8);

    wr(4'd3, 2'b11, {32'd7, 32'd7});
    collide(2'b11, {32'd9, 32'd9}, "collide full", {32'd7, 32'd7}, {32'd9, 32'd9});
    collide(2'b10, {32'd5, 32'd5}, "collide lane1", {32'd9, 32'd9}, {32'd5, 32'd9});

    wr(4'd2, 2'b11, {32'h22, 32'h22});
    clr   = 1'b1;
    ren   = 1'b1;
    raddr = 4'd2;
    tick();
    first = cyc;
    idle();
    measure_busy("clr busy", 1'b1);
    set_exp(0, {32'h22, 32'h22});
    check_reads("clr inflight", first, 1);
    for (int i = 0; i < 16; i++) set_exp(i, 64'd0);
    rd_burst(0, 16, first);
    check_reads("clr zero", first, 16);

    wr(4'd14, 2'b11, {32'hEE, 32'hEE});
    for (int k = 0; k < 4; k++) exp_w[k][0] = (k == 3) ? 64'd0 : {32'hEE, 32'hEE};
    rd_burst(14, 1, first);
    check_reads("oor addr14", first, 1);
    set_exp(0, 64'd0);
    rd_burst(2, 1, first);
    check_reads("oor alias", first, 1);

    ren   = 1'b1;
    raddr = 4'd14;
    tick();
    raddr = 4'd5;
    tick();
    raddr = 4'd7;
    tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("midreset dvalid d%0d", k), 64'(dv_w[k]), 64'd0);
      check_val($sformatf("midreset busy d%0d", k), 64'(busy_w[k]), 64'd1);
    end
    clear_logs();
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    measure_busy("rerst busy", 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("rerst dropped d%0d", k), 64'(rd_q[k].size()), 64'd0);
    end
    clear_logs();
    set_exp(0, 64'd0);
    rd_burst(14, 1, first);
    check_reads("rerst zero", first, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
